counter_debouncer: RTL and testbench

- Multi-channel counter-based debouncer between the board push-button pins (BTNC/BTNL/BTNR) and the counter FSM inside Main.
- Each channel synchronizes its raw button input and accepts a new level only after it holds stable for DEBOUNCE_CYCLES clocks.
- Outputs the clean level plus single-cycle press and release pulses; the FSM consumes the press pulses as its T1/T2/T3 inputs.
- The reset button (BTNU) is not debounced here.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_channel.sv | 109 ++++++++++
 rtl/counter_debouncer.sv | 35 +++
 tb/tb_counter_debouncer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and parameter limits for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        DB_LOW,
        DB_RISING,
        DB_HIGH,
        DB_FALLING
    } db_state_t;

    localparam int unsigned DB_MIN_CYCLES = 2;
    localparam int unsigned DB_MIN_SYNC   = 2;

    function automatic bit db_params_ok(input int unsigned cycles, input int unsigned stages);
        return (cycles >= DB_MIN_CYCLES) && (stages >= DB_MIN_SYNC);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchronizer, stability counter and level FSM.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    db_state_t              r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   r_level, w_level_nxt;
    logic                   r_press, w_press_nxt;
    logic                   r_release, w_release_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_state   <= DB_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Any reversal during qualification drops back with cnt cleared: no partial credit.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            DB_LOW: begin
                if (w_s) begin
                    w_state_nxt = DB_RISING;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            DB_RISING: begin
                if (!w_s) begin
                    w_state_nxt = DB_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TERM) begin
                    w_state_nxt = DB_HIGH;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            DB_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = DB_FALLING;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            DB_FALLING: begin
                if (w_s) begin
                    w_state_nxt   = DB_HIGH;
                    w_cnt_nxt     = '0;
                end else if (r_cnt == TERM) begin
                    w_state_nxt   = DB_LOW;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt     = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = DB_LOW;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: rtl/counter_debouncer.sv
// Multi-channel push-button debouncer; press pulses feed the counter FSM in Main.
module counter_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    if (!db_params_ok(DEBOUNCE_CYCLES, SYNC_STAGES)) begin : g_param_check
        $error("counter_debouncer: DEBOUNCE_CYCLES and SYNC_STAGES must each be >= 2");
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule

// File: tb/tb_counter_debouncer.sv
// Self-checking bench for counter_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_counter_debouncer;

    logic       clk;
    logic       reset;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   step_no = 0;

    counter_debouncer #(
        .N_BUTTONS      (3),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic [2:0] raw,
                                input logic [2:0] lvl, input logic [2:0] prs,
                                input logic [2:0] rel);
        vec_t v;
        v.rst = rst; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        tbl.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic rst, input logic [2:0] raw,
                                  input logic [2:0] lvl, input logic [2:0] prs,
                                  input logic [2:0] rel);
        for (int k = 0; k < n; k++) add(rst, raw, lvl, prs, rel);
    endfunction

    task automatic check_one(input string name, input int idx,
                             input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    // Drive one edge's inputs, queue its expectation, then compare just after the edge.
    task automatic step(input logic rst, input logic [2:0] raw,
                        input logic [2:0] lvl, input logic [2:0] prs, input logic [2:0] rel);
        exp_t e;
        reset   = rst;
        btn_raw = raw;
        e.idx = step_no; e.lvl = lvl; e.prs = prs; e.rel = rel;
        exp_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty step=%0d actual=0 required=1", step_no);
        end else begin
            e = exp_q.pop_front();
            check_one("level",   e.idx, btn_level,   e.lvl);
            check_one("press",   e.idx, btn_press,   e.prs);
            check_one("release", e.idx, btn_release, e.rel);
            check_one("press_and_release", e.idx, btn_press & btn_release, 3'b000);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 3'b000;
        @(negedge clk);

        // Reset state
        add_n(2, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        // Clean press on channel 0: level and pulse at the 6th edge only
        add_n(5, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        add  (   1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
        add  (   1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        // Bring channel 2 high, then release it
        add_n(5, 1'b0, 3'b101, 3'b001, 3'b000, 3'b000);
        add  (   1'b0, 3'b101, 3'b101, 3'b100, 3'b000);
        add  (   1'b0, 3'b101, 3'b101, 3'b000, 3'b000);
        add_n(5, 1'b0, 3'b001, 3'b101, 3'b000, 3'b000);
        add  (   1'b0, 3'b001, 3'b001, 3'b000, 3'b100);
        add  (   1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        // Bounce on channel 1: 1,1,0,1,1,0 never qualifies
        add(1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        add(1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add_n(6, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        // Reset clears a debounced-high channel immediately
        add(1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        // Glitch of 3 clocks is rejected
        add_n(3, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        add_n(6, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        // 4-clock pulse qualifies, then its release qualifies too
        add_n(4, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        add  (   1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        add  (   1'b0, 3'b000, 3'b001, 3'b001, 3'b000);
        add_n(3, 1'b0, 3'b000, 3'b001, 3'b000, 3'b000);
        add  (   1'b0, 3'b000, 3'b000, 3'b000, 3'b001);
        add  (   1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        // Simultaneous press and release on all channels
        add_n(5, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        add  (   1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        add  (   1'b0, 3'b111, 3'b111, 3'b000, 3'b000);
        add_n(5, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000);
        add  (   1'b0, 3'b000, 3'b000, 3'b000, 3'b111);
        add  (   1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].rst, tbl[i].raw, tbl[i].lvl, tbl[i].prs, tbl[i].rel);

        // Reset mid-count with raw held high: restart, press 6 edges after the reset edge
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        step(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        step(1'b1, 3'b001, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 5; k++)
            step(1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        step(1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
        step(1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

        // Release interrupted by a bounce back high: no pulse, level stays high
        step(1'b0, 3'b000, 3'b001, 3'b000, 3'b000);
        step(1'b0, 3'b000, 3'b001, 3'b000, 3'b000);
        step(1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        for (int k = 0; k < 6; k++)
            step(1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
